// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M definitions: funct3 codes, mul/div FSM encoding, operand signedness.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // rs1 is treated as signed; rs2 is signed for the same set except MULHSU
  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*XLEN accumulator,
// both built around a single XLEN+1-bit adder.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0] x, y, sum;
  logic          cin;

  always_comb begin
    if (is_div) begin
      // remainder shifted left by one, minus divisor
      x   = acc[2*XLEN-1:XLEN-1];
      y   = ~{1'b0, opnd};
      cin = 1'b1;
    end else begin
      x   = {1'b0, acc[2*XLEN-1:XLEN]};
      y   = {1'b0, opnd};
      cin = 1'b0;
    end
    sum = x + y + {{XLEN{1'b0}}, cin};

    acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    if (is_div) begin
      // a set carry-out bit of the shifted remainder guarantees it exceeds the divisor
      if (acc[2*XLEN-1] || !sum[XLEN])
        acc_nxt = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Multi-cycle RV M-extension unit: operands become magnitudes, XLEN iterations run,
// then FIX restores the sign and picks the half the op asks for.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_nxt;
  logic [2:0]          op;
  logic [2*XLEN-1:0]   acc, acc_nxt, prod;
  logic [XLEN-1:0]     opnd, mag1, mag2, fast_res, fix_res;
  logic                sgn_q, sgn_r, neg1, neg2, div0, ovf, fast;
  logic [CNT_W-1:0]    cnt;

  assign neg1 = is_signed_op(funct3) && rs1[XLEN-1];
  assign neg2 = is_signed_op(funct3) && (funct3 != F3_MULHSU) && rs2[XLEN-1];
  assign mag1 = neg1 ? -rs1 : rs1;
  assign mag2 = neg2 ? -rs2 : rs2;

  assign div0     = funct3[2] && (rs2 == '0);
  assign ovf      = (funct3 == F3_DIV || funct3 == F3_REM) && (rs1 == MIN_INT) && (&rs2);
  assign fast     = div0 || ovf;
  assign fast_res = div0 ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (op[2]),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    prod    = sgn_q ? -acc : acc;
    fix_res = '0;
    case (op)
      F3_MUL:                    fix_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:           fix_res = sgn_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                   fix_res = sgn_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = fast ? S_DONE : S_CALC;
      S_CALC:  if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      acc    <= '0;
      opnd   <= '0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (start) begin
          op    <= funct3;
          cnt   <= '0;
          sgn_q <= neg1 ^ neg2;
          sgn_r <= neg1;
          // low half carries the multiplier or the dividend; opnd the other operand
          acc   <= {{XLEN{1'b0}}, funct3[2] ? mag1 : mag2};
          opnd  <= funct3[2] ? mag2 : mag1;
          if (fast) result <= fast_res;
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        S_FIX:   result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_riscv_muldiv.sv
// Randomised scoreboard bench for riscv_muldiv (XLEN=32) with directed corner cases.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0, cyc = 0;
  logic [31:0] last_res;

  riscv_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the M-extension definitions
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    logic            ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done result=%h at cycle %0d", result, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", {32'b0, result}, {32'b0, mon_e.res});
        chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
  endtask

  task automatic push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = model(f3, a, b);
    e.lat = is_fast(f3, a, b) ? 1 : 34;
    e.t0  = cyc;
    sbq.push_back(e);
    last_res = e.res;
  endtask

  task automatic wait_idle(output int bc);
    bc = 0;
    for (int t = 0; t < 100; t++) begin
      if (!busy) break;
      bc++;
      @(negedge clk);
    end
    chk("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int bc);
    drive(f3, a, b);
    push(f3, a, b);
    @(negedge clk);
    start = 1'b0;
    wait_idle(bc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    rst = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, bc);
    chk("mul_busy_cycles", 64'(bc), 64'd34);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, bc);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, bc);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, bc);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, bc);
    issue(3'd5, 32'd100, 32'd7, bc);
    issue(3'd7, 32'd100, 32'd7, bc);
    issue(3'd5, 32'd5, 32'd0, bc);
    chk("fast_busy_cycles", 64'(bc), 64'd1);
    issue(3'd6, 32'd5, 32'd0, bc);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, bc);

    // flush mid-CALC: no done, result untouched
    drive(3'd0, 32'd12345, 32'd678);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_result", {32'b0, result}, {32'b0, last_res});
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd12345, 32'd678, bc);

    // start together with flush in IDLE is dropped
    drive(3'd0, 32'd3, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {63'b0, busy}, 64'd0);

    // start while busy is ignored
    drive(3'd0, 32'd1000, 32'd1000);
    push(3'd0, 32'd1000, 32'd1000);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(bc);

    // start during the done cycle is ignored
    drive(3'd5, 32'd100, 32'd7);
    push(3'd5, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 100 && !done; t++) @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", {63'b0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // async reset mid-CALC
    drive(3'd0, 32'd99, 32'd99);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_result", {32'b0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'd4, 32'd9, 32'd3, bc);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, bc);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
